// File: rtl/if_stage_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
// The fetch stage (master) presents an address and a request; the memory
// (slave) answers with the instruction word and a ready strobe.
interface if_stage_if #(
   parameter int PC_WIDTH   = 32,
   parameter int INST_WIDTH = 32
);
   logic [PC_WIDTH-1:0]   imem_addr;
   logic                  imem_req;
   logic [INST_WIDTH-1:0] imem_rdata;
   logic                  imem_ready;

   modport master (
      output imem_addr,
      output imem_req,
      input  imem_rdata,
      input  imem_ready
   );

   modport slave (
      input  imem_addr,
      input  imem_req,
      output imem_rdata,
      output imem_ready
   );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the program counter, issues fetches on the
// instruction-memory bus and fills the IF/ID pipeline register. Redirects
// from EX override everything; stalls, holds and memory waits insert bubbles
// or freeze state, and every non-redirect fetch stall is counted.
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif

module if_stage #(
   parameter int                    PC_WIDTH       = 32,
   parameter int                    INST_WIDTH     = 32,
   parameter int                    REG_ADDR_WIDTH = `REG_ADDR_WIDTH,
   parameter logic [PC_WIDTH-1:0]   RESET_PC       = 32'h0000_0000,
   parameter logic [INST_WIDTH-1:0] NOP_INST       = 32'h0000_0013
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      pc_write,
   input  logic                      IF_ID_write,
   input  logic                      IF_ID_flush,
   input  logic                      branch_taken,
   input  logic [PC_WIDTH-1:0]       branch_target,
   if_stage_if.master                imem,
   output logic [PC_WIDTH-1:0]       IF_ID_pc,
   output logic [PC_WIDTH-1:0]       IF_ID_pc_plus4,
   output logic [INST_WIDTH-1:0]     IF_ID_inst,
   output logic                      IF_ID_valid,
   output logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1,
   output logic [REG_ADDR_WIDTH-1:0] IF_ID_rs2,
   output logic [15:0]               stall_count
);

   // Saturating increment: the counter sticks at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Fetch PC (stage 0) and IF/ID register (stage 1)
   logic [PC_WIDTH-1:0]   pc_p0;
   logic [PC_WIDTH-1:0]   pc_plus4_p0;
   logic [PC_WIDTH-1:0]   pc_nxt;

   logic [PC_WIDTH-1:0]   pc_p1;
   logic [PC_WIDTH-1:0]   pc_plus4_p1;
   logic [INST_WIDTH-1:0] inst_p1;
   logic                  vld_p1;

   logic [PC_WIDTH-1:0]   pc_p1_nxt;
   logic [PC_WIDTH-1:0]   pc_plus4_p1_nxt;
   logic [INST_WIDTH-1:0] inst_p1_nxt;
   logic                  vld_p1_nxt;

   logic                  stall_hit;
   logic [15:0]           stall_cnt;

   // Sequential successor wraps naturally at the top of the address space.
   assign pc_plus4_p0 = pc_p0 + PC_WIDTH'(4);

   assign imem.imem_addr = pc_p0;
   assign imem.imem_req  = ~rst;

   // A fetch stall is any non-redirect cycle in which the PC cannot advance.
   assign stall_hit = ~branch_taken & (~pc_write | ~imem.imem_ready);

   // Next PC: redirect wins, then an accepted fetch advances, else hold.
   always_comb begin
      pc_nxt = pc_p0;
      if (branch_taken) begin
         pc_nxt = branch_target;
      end else if (pc_write && imem.imem_ready) begin
         pc_nxt = pc_plus4_p0;
      end
   end

   // Next IF/ID contents: redirect squashes, disabled write holds (even over
   // a flush), flush or missing data inserts a bubble, otherwise load.
   always_comb begin
      pc_p1_nxt       = pc_p1;
      pc_plus4_p1_nxt = pc_plus4_p1;
      inst_p1_nxt     = inst_p1;
      vld_p1_nxt      = vld_p1;
      if (branch_taken || (IF_ID_write && (IF_ID_flush || !imem.imem_ready))) begin
         pc_p1_nxt       = '0;
         pc_plus4_p1_nxt = '0;
         inst_p1_nxt     = NOP_INST;
         vld_p1_nxt      = 1'b0;
      end else if (IF_ID_write) begin
         pc_p1_nxt       = pc_p0;
         pc_plus4_p1_nxt = pc_plus4_p0;
         inst_p1_nxt     = imem.imem_rdata;
         vld_p1_nxt      = 1'b1;
      end
   end

   // PC register; reset restarts fetch at RESET_PC.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_p0 <= RESET_PC;
      end else begin
         pc_p0 <= pc_nxt;
      end
   end

   // ---- stage boundary: fetch -> IF/ID ----
   // IF/ID register; reset leaves a bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_p1       <= '0;
         pc_plus4_p1 <= '0;
         inst_p1     <= NOP_INST;
         vld_p1      <= 1'b0;
      end else begin
         pc_p1       <= pc_p1_nxt;
         pc_plus4_p1 <= pc_plus4_p1_nxt;
         inst_p1     <= inst_p1_nxt;
         vld_p1      <= vld_p1_nxt;
      end
   end

   // Fetch-stall cycle counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (stall_hit) begin
         stall_cnt <= sat_inc16(stall_cnt);
      end
   end

   assign IF_ID_pc       = pc_p1;
   assign IF_ID_pc_plus4 = pc_plus4_p1;
   assign IF_ID_inst     = inst_p1;
   assign IF_ID_valid    = vld_p1;
   assign IF_ID_rs1      = inst_p1[15 +: REG_ADDR_WIDTH];
   assign IF_ID_rs2      = inst_p1[20 +: REG_ADDR_WIDTH];
   assign stall_count    = stall_cnt;

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 32: program counter and instruction address width.
REQ-002 SHALL have parameter INST_WIDTH, default 32: instruction word width.
REQ-003 SHALL have parameter REG_ADDR_WIDTH, default `REG_ADDR_WIDTH: register index width.
REQ-004 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-005 SHALL have parameter NOP_INST, default 32'h0000_0013: bubble instruction (addi x0,x0,0).
REQ-006 SHALL have port clk  input  1  single clock, rising-edge.
REQ-007 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-008 SHALL have port pc_write  input  1  PC update enable; low means stall.
REQ-009 SHALL have port IF_ID_write  input  1  IF/ID load enable; low means hold.
REQ-010 SHALL have port IF_ID_flush  input  1  IF/ID bubble request.
REQ-011 SHALL have port branch_taken  input  1  redirect from EX.
REQ-012 SHALL have port branch_target  input  PC_WIDTH  redirect address.
REQ-013 SHALL have port imem_addr  output  PC_WIDTH  instruction memory address.
REQ-014 SHALL have port imem_req  output  1  fetch request.
REQ-015 SHALL have port imem_rdata  input  INST_WIDTH  fetched instruction, valid when imem_ready.
REQ-016 SHALL have port imem_ready  input  1  instruction memory data valid this cycle.
REQ-017 SHALL have ports IF_ID_pc and IF_ID_pc_plus4  output  PC_WIDTH  registered PC and PC+4.
REQ-018 SHALL have port IF_ID_inst  output  INST_WIDTH  registered instruction.
REQ-019 SHALL have port IF_ID_valid  output  1  IF/ID holds a real instruction.
REQ-020 SHALL have ports IF_ID_rs1 and IF_ID_rs2  output  REG_ADDR_WIDTH  IF_ID_inst[19:15] and [24:20], combinational from the register.
REQ-021 SHALL have port stall_count  output  16  saturating fetch-stall cycle counter.

Function
REQ-022 SHALL drive imem_addr = PC register (combinational) and imem_req = 1 whenever rst is low.
REQ-023 SHALL update the PC at each edge with priority: branch_taken -> branch_target; else pc_write & imem_ready -> PC+4 (mod 2^PC_WIDTH, so 0xFFFF_FFFC wraps to 0); else hold.
REQ-024 SHALL update IF/ID at each edge with priority:
  - branch_taken -> bubble, regardless of IF_ID_write.
  - !IF_ID_write -> hold all IF/ID fields, even if IF_ID_flush is high.
  - IF_ID_flush -> bubble.
  - !imem_ready -> bubble.
  - otherwise load: pc=PC, pc_plus4=PC+4, inst=imem_rdata, valid=1.
REQ-025 SHALL define a bubble as inst=NOP_INST, valid=0, pc=0, pc_plus4=0.
REQ-026 SHALL load an instruction in the same cycle the PC advances; fetch-to-IF/ID latency is 1 cycle.
REQ-027 SHALL make the first instruction from branch_target visible in IF/ID one cycle after the redirect edge, given imem_ready.
REQ-028 SHALL increment stall_count at edges where branch_taken=0 and (pc_write=0 or imem_ready=0), saturating at 16'hFFFF.
REQ-029 SHALL ignore imem_rdata when imem_ready is low.

Reset
REQ-030 SHALL, on rst high, asynchronously set PC=RESET_PC, IF/ID to a bubble, and stall_count=0.
REQ-031 SHALL hold imem_req=0 while rst is high, and resume fetching from RESET_PC at the first edge after rst falls.
REQ-032 SHALL discard a stall or redirect that coincides with reset assertion.

Verification
REQ-033 SHALL cover sequential fetch: reset release, imem_ready=1, all enables high -> IF_ID_pc reads 0,4,8,12 on successive cycles, with valid=1.
REQ-034 SHALL cover a load-use stall: pc_write=0, IF_ID_write=0 and IF_ID_flush=1 for 1 cycle at PC=0x10 -> PC stays 0x10; IF/ID keeps the 0x0C instruction; stall_count increments by 1.
REQ-035 SHALL cover a branch: branch_taken=1, target 0x100, with IF_ID_write=0 -> next cycle valid=0 and inst=0x00000013; the following cycle IF_ID_pc=0x100.
REQ-036 SHALL cover a memory wait: imem_ready=0 for 3 cycles at PC=0x20 -> 3 bubbles, PC held at 0x20, stall_count +3; then IF_ID_pc=0x20.
REQ-037 SHALL cover wrap and saturation: PC=0xFFFF_FFFC advances -> PC=0; 70000 stall cycles -> stall_count=0xFFFF.
REQ-038 SHALL cover mid-operation reset: rst pulse during a stall -> immediately PC=RESET_PC, valid=0, stall_count=0.
